// File: rtl/gemm_pkg.sv
// gemm_pkg: shared FSM type and drain-length helper for the GEMM feeder.
// Option: GEMM_FEEDER_INPUT_SKEW_EN selects internal lane skew.
package gemm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DRAIN
   } feed_state_e;

`ifdef GEMM_FEEDER_INPUT_SKEW_EN
   localparam bit SKEW_EN = 1'b1;
`else
   localparam bit SKEW_EN = 1'b0;
`endif

   // Cycles from the last accepted beat until it reaches the far corner MAC.
   function automatic int drain_len(input int dim, input bit skew);
      return skew ? (2 * dim - 1) : dim;
   endfunction

endpackage

// File: rtl/gemm_delay_line.sv
// gemm_delay_line: data + enable shift register exposing every stage.
// Stage 0 is loaded from the input; all stages shift every cycle.
module gemm_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [WIDTH-1:0]         d_i,
   input  logic                     ena_i,
   output logic [DEPTH*WIDTH-1:0]   tap_o,
   output logic [DEPTH-1:0]         ena_o
);

   logic [DEPTH*WIDTH-1:0] data_q, data_d;
   logic [DEPTH-1:0]       ena_q, ena_d;

   // Next state: shift every stage up by one, load stage 0 from input.
   always_comb begin
      data_d = data_q;
      ena_d  = ena_q;
      data_d[WIDTH-1:0] = d_i;
      ena_d[0]          = ena_i;
      for (int s = 1; s < DEPTH; s++) begin
         data_d[s*WIDTH +: WIDTH] = data_q[(s-1)*WIDTH +: WIDTH];
         ena_d[s]                 = ena_q[s-1];
      end
   end

   // Stage registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
         ena_q  <= '0;
      end else begin
         data_q <= data_d;
         ena_q  <= ena_d;
      end
   end

   assign tap_o = data_q;
   assign ena_o = ena_q;

endmodule

// File: rtl/gemm_skew_feeder.sv
// gemm_skew_feeder: operand feeder for a DIM x DIM output-stationary array.
// Option: GEMM_FEEDER_INPUT_SKEW_EN adds per-lane skew ahead of the chains.
module gemm_skew_feeder
   import gemm_pkg::*;
#(
   parameter int OP_WIDTH = 8,
   parameter int DIM      = 4,
   parameter int K_MAX    = 256
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [DIM*OP_WIDTH-1:0]          in_a_column,
   input  logic [DIM*OP_WIDTH-1:0]          in_b_row,
   input  logic                             in_valid,
   input  logic                             in_last,
   output logic                             in_ready,
   output logic [DIM*DIM*OP_WIDTH-1:0]      mac_a,
   output logic [DIM*DIM*OP_WIDTH-1:0]      mac_b,
   output logic [DIM*DIM-1:0]               mac_a_ena,
   output logic [DIM*DIM-1:0]               mac_b_ena,
   output logic                             tile_done,
   output logic [$clog2(K_MAX+1)-1:0]       k_count,
   output logic                             k_overflow
);

   localparam int LW = DIM * OP_WIDTH;
   localparam int D  = drain_len(DIM, SKEW_EN);
   localparam int CW = $clog2(D);
   localparam int KW = $clog2(K_MAX + 1);

   feed_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] k_q, k_d;
   logic          ovf_q, ovf_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;

   logic          accept;
   logic [LW-1:0] feed_a, feed_b;

   assign accept = in_valid && ready_q;
   assign feed_a = accept ? in_a_column : '0;
   assign feed_b = accept ? in_b_row : '0;

   // A lanes: optional skew, then a DIM-deep chain tapped per column.
   for (genvar r = 0; r < DIM; r++) begin : g_a
      logic [OP_WIDTH-1:0] sk_d;
      logic                sk_e;
      logic [LW-1:0]       tap;
      logic [DIM-1:0]      tap_e;
`ifdef GEMM_FEEDER_INPUT_SKEW_EN
      if (r == 0) begin : g_ns
         assign sk_d = feed_a[OP_WIDTH-1:0];
         assign sk_e = accept;
      end else begin : g_sk
         logic [r*OP_WIDTH-1:0] st;
         logic [r-1:0]          st_e;
         gemm_delay_line #(
            .WIDTH (OP_WIDTH),
            .DEPTH (r)
         ) u_skew (
            .clk_i  (clk),
            .rst_ni (reset_n),
            .d_i    (feed_a[r*OP_WIDTH +: OP_WIDTH]),
            .ena_i  (accept),
            .tap_o  (st),
            .ena_o  (st_e)
         );
         assign sk_d = st[(r-1)*OP_WIDTH +: OP_WIDTH];
         assign sk_e = st_e[r-1];
      end
`else
      assign sk_d = feed_a[r*OP_WIDTH +: OP_WIDTH];
      assign sk_e = accept;
`endif
      gemm_delay_line #(
         .WIDTH (OP_WIDTH),
         .DEPTH (DIM)
      ) u_chain (
         .clk_i  (clk),
         .rst_ni (reset_n),
         .d_i    (sk_d),
         .ena_i  (sk_e),
         .tap_o  (tap),
         .ena_o  (tap_e)
      );
      for (genvar c = 0; c < DIM; c++) begin : g_tap
         assign mac_a[(r*DIM+c)*OP_WIDTH +: OP_WIDTH] =
            tap[c*OP_WIDTH +: OP_WIDTH];
         assign mac_a_ena[r*DIM+c] = tap_e[c];
      end
   end

   // B lanes: optional skew, then a DIM-deep chain tapped per row.
   for (genvar c = 0; c < DIM; c++) begin : g_b
      logic [OP_WIDTH-1:0] sk_d;
      logic                sk_e;
      logic [LW-1:0]       tap;
      logic [DIM-1:0]      tap_e;
`ifdef GEMM_FEEDER_INPUT_SKEW_EN
      if (c == 0) begin : g_ns
         assign sk_d = feed_b[OP_WIDTH-1:0];
         assign sk_e = accept;
      end else begin : g_sk
         logic [c*OP_WIDTH-1:0] st;
         logic [c-1:0]          st_e;
         gemm_delay_line #(
            .WIDTH (OP_WIDTH),
            .DEPTH (c)
         ) u_skew (
            .clk_i  (clk),
            .rst_ni (reset_n),
            .d_i    (feed_b[c*OP_WIDTH +: OP_WIDTH]),
            .ena_i  (accept),
            .tap_o  (st),
            .ena_o  (st_e)
         );
         assign sk_d = st[(c-1)*OP_WIDTH +: OP_WIDTH];
         assign sk_e = st_e[c-1];
      end
`else
      assign sk_d = feed_b[c*OP_WIDTH +: OP_WIDTH];
      assign sk_e = accept;
`endif
      gemm_delay_line #(
         .WIDTH (OP_WIDTH),
         .DEPTH (DIM)
      ) u_chain (
         .clk_i  (clk),
         .rst_ni (reset_n),
         .d_i    (sk_d),
         .ena_i  (sk_e),
         .tap_o  (tap),
         .ena_o  (tap_e)
      );
      for (genvar r = 0; r < DIM; r++) begin : g_tap
         assign mac_b[(r*DIM+c)*OP_WIDTH +: OP_WIDTH] =
            tap[r*OP_WIDTH +: OP_WIDTH];
         assign mac_b_ena[r*DIM+c] = tap_e[r];
      end
   end

   // Tile framing: beat counting, drain countdown and ready/done flags.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      if (accept) begin
         if (k_q != KW'(K_MAX)) begin
            k_d = k_q + KW'(1);
         end else if (!in_last) begin
            ovf_d = 1'b1;
         end
      end
      unique case (state_q)
         ST_IDLE, ST_STREAM: begin
            if (accept) begin
               if (in_last) begin
                  state_d = ST_DRAIN;
                  cnt_d   = CW'(D - 1);
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end
         ST_DRAIN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               k_d     = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d != ST_DRAIN);
   end

   // Control registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign in_ready   = ready_q;
   assign tile_done  = done_q;
   assign k_count    = k_q;
   assign k_overflow = ovf_q;

endmodule

// File: doc/gemm_skew_feeder.md
# gemm_skew_feeder

Parametrised operand feeder for a DIM×DIM output-stationary systolic GEMM array. Accepts one A column and one B row per beat over a valid/ready handshake, optionally skews them internally, and shifts them through per-row/per-column register chains so every MAC gets its operand pair and enables on the same cycle. Frames work into tiles: it drains the array after the last beat of a tile, pulses `tile_done`, and holds off new input during the drain. Sits between the operand buffers and the MAC grid.

## Interface
- `OP_WIDTH`, 8, operand width in bits
- `DIM`, 4, array dimension (≥2); rows and columns of MACs
- `K_MAX`, 256, maximum beats per tile before overflow is flagged
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  reset; asynchronous, active-low
- `in_a_column`  in  DIM*OP_WIDTH  A column, lane r = row r at bits [r*OP_WIDTH +: OP_WIDTH]
- `in_b_row`  in  DIM*OP_WIDTH  B row, lane c = column c
- `in_valid`  in  1  beat present
- `in_last`  in  1  beat is the final k-step of the tile; ignored unless `in_valid`
- `in_ready`  out  1  feeder accepts a beat this cycle
- `mac_a`, `mac_b`  out  DIM*DIM*OP_WIDTH  operand for MAC(r,c) at index (r*DIM+c)
- `mac_a_ena`, `mac_b_ena`  out  DIM*DIM  operand valid per MAC
- `tile_done`  out  1  one-cycle pulse: final operands of the tile present at MAC(DIM-1,DIM-1)
- `k_count`  out  $clog2(K_MAX+1)  beats accepted in current tile (saturating)
- `k_overflow`  out  1  sticky: more than K_MAX beats without `in_last`

## Operation
- Accept = `in_valid && in_ready` at a rising edge.
- Lane pipeline: A row r has a chain of DIM registers; MAC(r,c) taps stage c. B column c likewise; MAC(r,c) taps stage r. Chains shift every cycle regardless of accept.
- Stage-0 load: on accept, lane data and ena=1; otherwise data=0, ena=0 (bubble).
- FSM states IDLE, STREAM, DRAIN:
  - IDLE→STREAM on accept without `in_last`; IDLE→DRAIN on accept with `in_last` (single-beat tile).
  - STREAM→DRAIN on accept with `in_last`; bubbles keep STREAM.
  - DRAIN: drain counter loaded with D−1 on entry, decrements each cycle; at zero → IDLE and `tile_done` asserted that cycle.
- D (drain length) = 2*DIM−1 with skew enabled, DIM without.
- `in_ready` is a register: 0 in reset, 1 from first edge after release, cleared on the edge accepting `in_last`, set on the edge leaving DRAIN.
- `k_count`: cleared on entering IDLE, incremented per accept, saturates at K_MAX. Accept while `k_count==K_MAX` and no `in_last` sets `k_overflow`; data still fed. `k_overflow` clears only on reset.
- Reset mid-tile/mid-drain: all chains, enables, counters, `tile_done` cleared to 0 immediately; no `tile_done` emitted for the aborted tile.

## Timing
- Reset values: all `mac_*` 0, all enables 0, `in_ready` 0, `tile_done` 0, `k_count` 0, `k_overflow` 0.
- Beat accepted at edge t: A lane r reaches MAC(r,c) at cycle t+c+1 (+r with skew); B lane c reaches MAC(r,c) at t+r+1 (+c with skew).
- Last beat accepted at t: `tile_done` high in cycle t+D; `in_ready` high from the same edge; next beat earliest at t+D+1.
- Max throughput one beat/cycle within a tile.

## Configuration
- `GEMM_FEEDER_INPUT_SKEW_EN` defined: A lane r delayed r extra cycles, B lane c delayed c extra, before the chains; both operands of a k-step meet at MAC(r,c) at t+r+c+1; D=2*DIM−1.
- Undefined: no internal skew; upstream supplies pre-skewed lanes; D=DIM; skew registers absent.

## Structure
- Shared package `gemm_pkg`: FSM state enum typedef, function computing drain length from DIM and skew setting.
- Sub-module `gemm_delay_line` (parameters WIDTH, DEPTH; data + ena shift register with per-stage taps, async active-low reset); instantiated for A/B chains and skew stages.

## Test plan
- DIM=2, skew on, tile of 2 beats A=[1,2],[3,4], B=[5,6],[7,8], back-to-back -> each MAC sees matching k-pairs with both enables high same cycle; `tile_done` at t_last+3; `k_count`=2 before clear.
- DIM=4, bubble: valid 1,0,1 with last on third cycle -> bubble slot shows ena=0, data 0 at all MACs; `k_count`=2; `tile_done` at t_last+7.
- Single-beat tile (valid+last first beat from IDLE) -> IDLE→DRAIN directly; `in_ready` low cycles t+1..t+D−1, high at t+D.
- K_MAX=4, 6 beats without last -> `k_count` stays 4, `k_overflow` set on beat 5 and remains set after tile ends.
- Reset_n low mid-DRAIN -> outputs zero asynchronously; no `tile_done`; `in_ready` 1 one edge after release.
- Skew macro undefined, DIM=4 -> `tile_done` at t_last+4; A lane 0 reaches MAC(0,3) at t+4.
